rt_avalon_ctrl_mc: RTL and testbench
====================================

RT_AVALON_CTRL_MC -- requirements
Module: rt_avalon_ctrl_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of raytracer channels (legal 1..16).
REQ-002 SHALL have parameter STAT_W, default 32, width of per-channel end status (legal 1..32).
REQ-003 SHALL have parameter CNT_W, default 32, width of per-channel runtime counter (legal 1..32).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port avs_s0_address  in  6  word address.
REQ-007 SHALL have port avs_s0_write  in  1  write strobe.
REQ-008 SHALL have port avs_s0_writedata  in  32  write data.
REQ-009 SHALL have port avs_s0_read  in  1  read strobe.
REQ-010 SHALL have port avs_s0_readdata  out  32  read data, fixed latency 1.
REQ-011 SHALL have port rdirq  out  1  level interrupt.
REQ-012 SHALL have port start_rt  out  NUM_CH  per-channel one-cycle start pulse.
REQ-013 SHALL have port end_rt  in  NUM_CH  per-channel one-cycle done pulse.
REQ-014 SHALL have port end_rtstat  in  NUM_CH*STAT_W  per-channel status, channel i at [i*STAT_W +: STAT_W].
REQ-015 SHALL have ports av_clk, av_reset  out  1  direct copies of clk, reset.

Function
REQ-016 Address map (words): 0 CTRL (W: bit i = start ch i; R: busy vector); 1 PENDING (R; W1C); 2 IRQ_MASK (RW, low NUM_CH bits); 3 INFO (R: {16'h0, STAT_W[7:0], NUM_CH[7:0]}); 4+2i STAT_i (R); 5+2i CYCLES_i (R), i < NUM_CH.
REQ-017 Reads SHALL return data on avs_s0_readdata the cycle after avs_s0_read; unmapped or i>=NUM_CH addresses SHALL read 0; unused upper bits SHALL read 0; no waitrequest.
REQ-018 Each channel SHALL run FSM IDLE -> BUSY on accepted start, BUSY -> IDLE on end_rt[i].
REQ-019 CTRL write bit i with channel IDLE SHALL pulse start_rt[i] for exactly one cycle, the cycle after the write, and enter BUSY that same cycle; bit i with channel BUSY SHALL be ignored.
REQ-020 end_rt[i] in BUSY SHALL capture end_rtstat slice into STAT_i, set pending[i], freeze CYCLES_i; end_rt[i] in IDLE SHALL be ignored.
REQ-021 CYCLES_i SHALL clear on start, increment each BUSY cycle, saturate at all-ones (no wrap).
REQ-022 Reading STAT_i SHALL clear pending[i]; writing 1 to PENDING bit i SHALL clear pending[i].
REQ-023 end_rt[i] coincident with a clearing read/W1C of channel i: set wins, pending[i]=1; read data returns pre-update STAT_i.
REQ-024 Start accepted while pending[i]=1 SHALL leave pending[i] and STAT_i unchanged.
REQ-025 rdirq SHALL be registered |(pending & IRQ_MASK), updating one cycle after the causing event.
REQ-026 Simultaneous end_rt on several channels SHALL be captured all in the same cycle; no loss.
REQ-027 Write and read in the same cycle SHALL both be honoured; read returns pre-write value.

Reset
REQ-028 On reset: all channels IDLE, start_rt=0, pending=0, IRQ_MASK=all ones, STAT_i=0, CYCLES_i=0, rdirq=0, avs_s0_readdata=0.
REQ-029 Reset mid-run SHALL abort BUSY to IDLE with no start_rt pulse; end_rt in the reset cycle is discarded.

Structure
REQ-030 Package rt_ctrl_pkg SHALL hold register address constants, ADDR_W=6, DATA_W=32, and channel state enum (IDLE, BUSY).
REQ-031 Per-channel FSM, status latch and counter SHALL be sub-module rt_chan_ctrl, instantiated NUM_CH times via generate.

Verification
REQ-032 Reset, write CTRL=0x1 -> start_rt=0001 one cycle later for 1 cycle; CTRL read = 0x1.
REQ-033 end_rt[0] with stat 0xDEADBEEF after 10 BUSY cycles -> PENDING=0x1, rdirq=1 next cycle, STAT_0=0xDEADBEEF, CYCLES_0=10; read STAT_0 -> rdirq=0.
REQ-034 CTRL=0x1 twice while ch0 BUSY -> second write yields no start_rt pulse.
REQ-035 end_rt=1111 same cycle, IRQ_MASK=0x4 -> PENDING=0xF, rdirq=1; W1C 0x4 -> rdirq=0, PENDING=0xB.
REQ-036 end_rt[1] coincident with read of STAT_1 -> read returns old STAT_1, pending[1] stays 1.
REQ-037 CNT_W=4, run 20 cycles -> CYCLES_0=15; reset mid-BUSY -> CTRL read 0.

Source files
------------

// File: rtl/rt_ctrl_pkg.sv
// Shared constants and types for the raytracer Avalon control block.
package rt_ctrl_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  // Word addresses of the register map.
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 6'd0;
  localparam logic [ADDR_W-1:0] ADDR_PENDING  = 6'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 6'd2;
  localparam logic [ADDR_W-1:0] ADDR_INFO     = 6'd3;
  localparam logic [ADDR_W-1:0] ADDR_CH_BASE  = 6'd4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ch_state_e;

  // Channel registers are interleaved: STAT_i at 4+2i, CYCLES_i at 5+2i.
  function automatic logic [ADDR_W-1:0] stat_addr(input int ch);
    return ADDR_CH_BASE + ADDR_W'(2 * ch);
  endfunction

  function automatic logic [ADDR_W-1:0] cycles_addr(input int ch);
    return ADDR_CH_BASE + ADDR_W'(2 * ch + 1);
  endfunction

endpackage

// File: rtl/rt_chan_ctrl.sv
// One raytracer channel: IDLE/BUSY sequencer, start pulse, end status latch
// and saturating runtime counter.
module rt_chan_ctrl
  import rt_ctrl_pkg::*;
#(
  parameter int STAT_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_req,
  input  logic              end_rt,
  input  logic [STAT_W-1:0] end_stat,
  output logic              start_rt,
  output logic              busy,
  output logic              done,
  output logic [STAT_W-1:0] stat,
  output logic [CNT_W-1:0]  cycles
);

  ch_state_e         state_q, state_d;
  logic              start_q, start_d;
  logic [STAT_W-1:0] stat_q,  stat_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Next-state logic: accept start in IDLE, count and watch for end in BUSY.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and a latch is never inferred.
    state_d = state_q;
    start_d = 1'b0;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = BUSY;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // Every BUSY cycle is counted, including the one carrying end_rt.
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (end_rt) begin
          state_d = IDLE;
          stat_d  = end_stat;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts a run and drops any end_rt in that cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      stat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_rt = start_q;
  assign busy     = (state_q == BUSY);
  assign stat     = stat_q;
  assign cycles   = cnt_q;

endmodule

// File: rtl/rt_avalon_ctrl_mc.sv
// Avalon-MM slave controlling NUM_CH raytracer channels: start, pending
// status with masked level interrupt, per-channel status and runtime readback.
module rt_avalon_ctrl_mc
  import rt_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int STAT_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        avs_s0_address,
  input  logic                     avs_s0_write,
  input  logic [DATA_W-1:0]        avs_s0_writedata,
  input  logic                     avs_s0_read,
  output logic [DATA_W-1:0]        avs_s0_readdata,
  output logic                     rdirq,
  output logic [NUM_CH-1:0]        start_rt,
  input  logic [NUM_CH-1:0]        end_rt,
  input  logic [NUM_CH*STAT_W-1:0] end_rtstat,
  output logic                     av_clk,
  output logic                     av_reset
);

  logic [NUM_CH-1:0] start_req;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] pend_clr;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] mask_q,    mask_d;
  logic              rdirq_q,   rdirq_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [DATA_W-1:0] rd_mux;
  logic [STAT_W-1:0] stat_arr [NUM_CH];
  logic [CNT_W-1:0]  cnt_arr  [NUM_CH];

  assign av_clk   = clk;
  assign av_reset = reset;

  assign start_req = (avs_s0_write && avs_s0_address == ADDR_CTRL)
                   ? avs_s0_writedata[NUM_CH-1:0] : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    rt_chan_ctrl #(
      .STAT_W (STAT_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .start_req (start_req[g]),
      .end_rt    (end_rt[g]),
      .end_stat  (end_rtstat[g*STAT_W +: STAT_W]),
      .start_rt  (start_rt[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .stat      (stat_arr[g]),
      .cycles    (cnt_arr[g])
    );
  end

  // Pending/mask update; a new end_rt wins over a same-cycle clear.
  always_comb begin
    pend_clr = '0;
    if (avs_s0_write && avs_s0_address == ADDR_PENDING)
      pend_clr = avs_s0_writedata[NUM_CH-1:0];
    if (avs_s0_read) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (avs_s0_address == stat_addr(i)) pend_clr[i] = 1'b1;
      end
    end
    pending_d = (pending_q & ~pend_clr) | done;
    mask_d    = mask_q;
    if (avs_s0_write && avs_s0_address == ADDR_IRQ_MASK)
      mask_d = avs_s0_writedata[NUM_CH-1:0];
    rdirq_d = |(pending_d & mask_d);
  end

  // Read mux from current register values, so a same-cycle write is not seen.
  always_comb begin
    rd_mux = '0;
    case (avs_s0_address)
      ADDR_CTRL:     rd_mux[NUM_CH-1:0] = busy;
      ADDR_PENDING:  rd_mux[NUM_CH-1:0] = pending_q;
      ADDR_IRQ_MASK: rd_mux[NUM_CH-1:0] = mask_q;
      ADDR_INFO:     rd_mux = {16'h0, 8'(STAT_W), 8'(NUM_CH)};
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (avs_s0_address == stat_addr(i))   rd_mux[STAT_W-1:0] = stat_arr[i];
          if (avs_s0_address == cycles_addr(i)) rd_mux[CNT_W-1:0]  = cnt_arr[i];
        end
      end
    endcase
    rdata_d = avs_s0_read ? rd_mux : '0;
  end

  // Bus-side registers: pending, mask, interrupt and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '1;
      rdirq_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      rdirq_q   <= rdirq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdirq           = rdirq_q;
  assign avs_s0_readdata = rdata_q;

endmodule

// File: tb/tb_rt_avalon_ctrl_mc.sv
// Directed bench for rt_avalon_ctrl_mc; a second instance with CNT_W=4
// shares all inputs to show counter saturation.
module tb_rt_avalon_ctrl_mc;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [5:0]   address = '0;
  logic         write = 1'b0;
  logic [31:0]  writedata = '0;
  logic         read = 1'b0;
  logic [3:0]   end_rt = '0;
  logic [127:0] end_rtstat = '0;

  logic [31:0] readdata, readdata4;
  logic        rdirq, rdirq4;
  logic [3:0]  start_rt, start_rt4;
  logic        av_clk, av_reset, av_clk4, av_reset4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rt_avalon_ctrl_mc u_dut (
    .clk(clk), .reset(reset),
    .avs_s0_address(address), .avs_s0_write(write), .avs_s0_writedata(writedata),
    .avs_s0_read(read), .avs_s0_readdata(readdata),
    .rdirq(rdirq), .start_rt(start_rt), .end_rt(end_rt), .end_rtstat(end_rtstat),
    .av_clk(av_clk), .av_reset(av_reset)
  );

  rt_avalon_ctrl_mc #(.NUM_CH(4), .STAT_W(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .avs_s0_address(address), .avs_s0_write(write), .avs_s0_writedata(writedata),
    .avs_s0_read(read), .avs_s0_readdata(readdata4),
    .rdirq(rdirq4), .start_rt(start_rt4), .end_rt(end_rt), .end_rtstat(end_rtstat),
    .av_clk(av_clk4), .av_reset(av_reset4)
  );

  // All driving and sampling happens on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a; write = 1'b1; writedata = d;
    cyc();
    write = 1'b0; writedata = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic [31:0] d4);
    address = a; read = 1'b1;
    cyc();
    read = 1'b0;
    d = readdata; d4 = readdata4;
  endtask

  task automatic test_reset();
    logic [31:0] d, d4;
    repeat (2) cyc();
    total++; if (av_reset !== 1'b1) begin bad++; $display("FAIL av_reset got=%b want=1", av_reset); end
    total++; if (av_clk !== clk) begin bad++; $display("FAIL av_clk got=%b want=%b", av_clk, clk); end
    total++; if (start_rt !== 4'b0) begin bad++; $display("FAIL rst_start got=%b want=0000", start_rt); end
    total++; if (rdirq !== 1'b0) begin bad++; $display("FAIL rst_rdirq got=%b want=0", rdirq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h want=0", readdata); end
    reset = 1'b0;
    cyc();
    rd(6'd0, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=0", d); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_pending got=%h want=0", d); end
    rd(6'd2, d, d4);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL rst_mask got=%h want=f", d); end
    rd(6'd3, d, d4);
    total++; if (d !== 32'h0000_2004) begin bad++; $display("FAIL info got=%h want=00002004", d); end
    rd(6'd4, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_stat0 got=%h want=0", d); end
    rd(6'd11, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_cycles3 got=%h want=0", d); end
    rd(6'd12, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped12 got=%h want=0", d); end
    rd(6'd63, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped63 got=%h want=0", d); end
  endtask

  task automatic test_start();
    logic [31:0] d, d4;
    wr(6'd0, 32'h1);
    total++; if (start_rt !== 4'b0001) begin bad++; $display("FAIL start_pulse got=%b want=0001", start_rt); end
    cyc();
    total++; if (start_rt !== 4'b0000) begin bad++; $display("FAIL start_one_cycle got=%b want=0000", start_rt); end
    rd(6'd0, d, d4);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ctrl_busy got=%h want=1", d); end
  endtask

  task automatic test_double_start();
    logic [31:0] d, d4;
    wr(6'd0, 32'h1);
    total++; if (start_rt !== 4'b0000) begin bad++; $display("FAIL restart_busy got=%b want=0000", start_rt); end
    cyc();
    total++; if (start_rt !== 4'b0000) begin bad++; $display("FAIL restart_busy2 got=%b want=0000", start_rt); end
    end_rt = 4'b0001; end_rtstat[31:0] = 32'h1234_5678;
    cyc();
    end_rt = '0;
    rd(6'd4, d, d4);
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL stat0_first got=%h want=12345678", d); end
  endtask

  task automatic test_end();
    logic [31:0] d, d4;
    wr(6'd0, 32'h1);            // now in BUSY cycle 1
    repeat (9) cyc();           // now in BUSY cycle 10
    end_rt = 4'b0001; end_rtstat[31:0] = 32'hDEAD_BEEF;
    cyc();
    end_rt = '0;
    total++; if (rdirq !== 1'b1) begin bad++; $display("FAIL end_rdirq got=%b want=1", rdirq); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL end_pending got=%h want=1", d); end
    rd(6'd5, d, d4);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL cycles0 got=%0d want=10", d); end
    rd(6'd0, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL end_idle got=%h want=0", d); end
    rd(6'd4, d, d4);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stat0 got=%h want=deadbeef", d); end
    total++; if (rdirq !== 1'b0) begin bad++; $display("FAIL rdclr_rdirq got=%b want=0", rdirq); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rdclr_pending got=%h want=0", d); end
    repeat (3) cyc();
    rd(6'd5, d, d4);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL cycles0_frozen got=%0d want=10", d); end
  endtask

  task automatic test_multi_end();
    logic [31:0] d, d4;
    wr(6'd0, 32'hF);
    total++; if (start_rt !== 4'b1111) begin bad++; $display("FAIL start_all got=%b want=1111", start_rt); end
    wr(6'd2, 32'h4);
    cyc();
    end_rt = 4'b1111;
    for (int i = 0; i < 4; i++) end_rtstat[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    cyc();
    end_rt = '0;
    total++; if (rdirq !== 1'b1) begin bad++; $display("FAIL multi_rdirq got=%b want=1", rdirq); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL multi_pending got=%h want=f", d); end
    wr(6'd1, 32'h4);
    total++; if (rdirq !== 1'b0) begin bad++; $display("FAIL w1c_rdirq got=%b want=0", rdirq); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'hB) begin bad++; $display("FAIL w1c_pending got=%h want=b", d); end
    rd(6'd10, d, d4);
    total++; if (d !== 32'hC0DE_0003) begin bad++; $display("FAIL stat3 got=%h want=c0de0003", d); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL rd3_pending got=%h want=3", d); end
    wr(6'd1, 32'hF);
    wr(6'd2, 32'hF);
  endtask

  task automatic test_collision();
    logic [31:0] d, d4;
    wr(6'd0, 32'h2);
    cyc();
    end_rt = 4'b0010; end_rtstat[63:32] = 32'h1111_0001;
    cyc();
    end_rt = '0;
    wr(6'd0, 32'h2);            // restart while pending[1] is set
    rd(6'd1, d, d4);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL start_keeps_pending got=%h want=2", d); end
    address = 6'd6; read = 1'b1; end_rt = 4'b0010; end_rtstat[63:32] = 32'h2222_0002;
    cyc();
    read = 1'b0; end_rt = '0;
    d = readdata;
    total++; if (d !== 32'h1111_0001) begin bad++; $display("FAIL collide_old_stat got=%h want=11110001", d); end
    total++; if (rdirq !== 1'b1) begin bad++; $display("FAIL collide_rdirq got=%b want=1", rdirq); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL collide_pending got=%h want=2", d); end
    rd(6'd6, d, d4);
    total++; if (d !== 32'h2222_0002) begin bad++; $display("FAIL collide_new_stat got=%h want=22220002", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, d4;
    address = 6'd2; write = 1'b1; writedata = 32'h5; read = 1'b1;
    cyc();
    write = 1'b0; read = 1'b0; writedata = '0;
    d = readdata;
    total++; if (d !== 32'hF) begin bad++; $display("FAIL rw_old_mask got=%h want=f", d); end
    rd(6'd2, d, d4);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL rw_new_mask got=%h want=5", d); end
    wr(6'd2, 32'hF);
  endtask

  task automatic test_saturate();
    logic [31:0] d, d4;
    wr(6'd0, 32'h1);            // BUSY cycle 1, counter 0
    repeat (20) cyc();          // counter now 20 in the wide instance
    rd(6'd5, d, d4);
    total++; if (d !== 32'd20) begin bad++; $display("FAIL cycles_wide got=%0d want=20", d); end
    total++; if (d4 !== 32'd15) begin bad++; $display("FAIL cycles_sat got=%0d want=15", d4); end
    reset = 1'b1; end_rt = 4'b0001; end_rtstat[31:0] = 32'hBAD0_BAD0;
    cyc();
    reset = 1'b0; end_rt = '0;
    total++; if (start_rt !== 4'b0000) begin bad++; $display("FAIL abort_start got=%b want=0000", start_rt); end
    rd(6'd0, d, d4);
    total++; if (d !== 32'h0 || d4 !== 32'h0) begin bad++; $display("FAIL abort_ctrl got=%h/%h want=0", d, d4); end
    rd(6'd1, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_pending got=%h want=0", d); end
    rd(6'd4, d, d4);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_stat0 got=%h want=0", d); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_start();
    test_double_start();
    test_end();
    test_multi_end();
    test_collision();
    test_back_to_back();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
